// File: rtl/clk_div_cfg.sv
// Configuration front-end for the clock divider: stops the divider, drains it,
// swaps in a new ratio and re-enables it, so the ratio never changes while running.
module clk_div_cfg #(
  parameter int RATIO_WD    = 4,
  parameter int RESET_RATIO = 1,
  parameter int DRAIN_CYC   = 16,
  parameter int SETTLE_CYC  = 2
) (
  input  logic                i_ref_clk,
  input  logic                i_rst,
  input  logic                i_enable,
  input  logic [RATIO_WD-1:0] i_cfg_ratio,
  input  logic                i_cfg_valid,
  output logic                o_cfg_ready,
  output logic                o_cfg_done,
  output logic                o_cfg_err,
  output logic                o_busy,
  output logic                o_clk_en,
  output logic [RATIO_WD-1:0] o_div_ratio
);

  localparam int CNT_MAX = (DRAIN_CYC > SETTLE_CYC) ? DRAIN_CYC : SETTLE_CYC;
  localparam int CNT_WD  = $clog2(CNT_MAX + 1);

  localparam logic [CNT_WD-1:0]   DRAIN_LAST  = CNT_WD'(DRAIN_CYC - 1);
  localparam logic [CNT_WD-1:0]   SETTLE_LAST = CNT_WD'(SETTLE_CYC - 1);
  localparam logic [CNT_WD-1:0]   CNT_SAT     = CNT_WD'(CNT_MAX);
  localparam logic [RATIO_WD-1:0] RST_RATIO   = RATIO_WD'(RESET_RATIO);

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_SETTLE = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [RATIO_WD-1:0] ratio_q, ratio_d;
  logic [RATIO_WD-1:0] pend_q, pend_d;
  logic [CNT_WD-1:0]   cnt_q, cnt_d;
  logic                clk_en_q, clk_en_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                ready_s;
  logic                req_s;
  logic                req_zero_s;
  logic                req_same_s;
  logic [CNT_WD-1:0]   cnt_inc_s;

  assign ready_s     = (state_q == ST_OFF) || (state_q == ST_RUN);
  assign o_cfg_ready = ready_s;
  assign o_busy      = (state_q == ST_DRAIN) || (state_q == ST_SETTLE);
  assign o_clk_en    = clk_en_q;
  assign o_div_ratio = ratio_q;
  assign o_cfg_done  = done_q;
  assign o_cfg_err   = err_q;

  // Request decode and saturating counter increment
  always_comb begin
    req_s      = ready_s && i_cfg_valid;
    req_zero_s = (i_cfg_ratio == {RATIO_WD{1'b0}});
    req_same_s = (i_cfg_ratio == ratio_q);
    if (cnt_q == CNT_SAT) begin
      cnt_inc_s = cnt_q;
    end else begin
      cnt_inc_s = cnt_q + CNT_WD'(1);
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    ratio_d = ratio_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_OFF: begin
        if (req_s && req_zero_s) begin
          err_d = 1'b1;
        end else if (req_s && req_same_s) begin
          done_d = 1'b1;
        end else if (req_s) begin
          // Divider is stopped, so the ratio can be swapped directly
          ratio_d = i_cfg_ratio;
          done_d  = 1'b1;
          state_d = i_enable ? ST_RUN : ST_OFF;
        end else begin
          state_d = i_enable ? ST_RUN : ST_OFF;
        end
      end
      ST_RUN: begin
        if (req_s && req_zero_s) begin
          err_d = 1'b1;
        end else if (req_s && req_same_s) begin
          done_d = 1'b1;
        end else if (req_s) begin
          pend_d  = i_cfg_ratio;
          cnt_d   = {CNT_WD{1'b0}};
          state_d = ST_DRAIN;
        end else begin
          state_d = i_enable ? ST_RUN : ST_OFF;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          ratio_d = pend_q;
          done_d  = 1'b1;
          cnt_d   = {CNT_WD{1'b0}};
          state_d = ST_SETTLE;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = {CNT_WD{1'b0}};
          state_d = i_enable ? ST_RUN : ST_OFF;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      default: begin
        state_d = ST_OFF;
      end
    endcase
    clk_en_d = (state_d == ST_RUN);
  end

  // State and output registers
  always_ff @(posedge i_ref_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q  <= ST_OFF;
      ratio_q  <= RST_RATIO;
      pend_q   <= {RATIO_WD{1'b0}};
      cnt_q    <= {CNT_WD{1'b0}};
      clk_en_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ratio_q  <= ratio_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
      clk_en_q <= clk_en_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_clk_div_cfg.sv
// Scoreboard bench for clk_div_cfg: stimulus queues expected done/err events and
// level expectations; a single monitor process does every comparison.
module tb_clk_div_cfg;

  localparam int DRAIN  = 16;
  localparam int SETTLE = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_enable;
  logic [3:0] i_cfg_ratio;
  logic       i_cfg_valid;
  logic       o_cfg_ready, o_cfg_done, o_cfg_err, o_busy, o_clk_en;
  logic [3:0] o_div_ratio;

  typedef struct {
    logic       is_err;
    logic [3:0] ratio;
    int         cyc;
  } ev_t;

  ev_t sb[$];

  logic       exp_clk_en, exp_ready, exp_busy;
  logic [3:0] exp_ratio;
  logic       chk_on    = 1'b0;
  logic       stim_done = 1'b0;
  int         cyc       = 0;
  int         checks    = 0;
  int         failures  = 0;

  clk_div_cfg #(.RATIO_WD(4), .RESET_RATIO(1), .DRAIN_CYC(DRAIN), .SETTLE_CYC(SETTLE)) dut (
    .i_ref_clk  (clk),
    .i_rst      (rst_n),
    .i_enable   (i_enable),
    .i_cfg_ratio(i_cfg_ratio),
    .i_cfg_valid(i_cfg_valid),
    .o_cfg_ready(o_cfg_ready),
    .o_cfg_done (o_cfg_done),
    .o_cfg_err  (o_cfg_err),
    .o_busy     (o_busy),
    .o_clk_en   (o_clk_en),
    .o_div_ratio(o_div_ratio)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input logic en, input logic [3:0] r, input logic rdy, input logic bsy);
    exp_clk_en = en;
    exp_ratio  = r;
    exp_ready  = rdy;
    exp_busy   = bsy;
  endtask

  task automatic push_ev(input logic is_err, input logic [3:0] r, input int at);
    ev_t e;
    e.is_err = is_err;
    e.ratio  = r;
    e.cyc    = at;
    sb.push_back(e);
  endtask

  // Full drain/settle reconfiguration from RUN, optional ignored request mid-drain
  task automatic reconfig(input logic [3:0] new_r, input logic [3:0] old_r,
                          input logic en_req, input logic pulse_mid);
    i_cfg_valid = 1'b1;
    i_cfg_ratio = new_r;
    i_enable    = en_req;
    push_ev(1'b0, new_r, cyc + 1 + DRAIN);
    tick();
    i_cfg_valid = 1'b0;
    set_exp(1'b0, old_r, 1'b0, 1'b1);
    for (int j = 1; j <= DRAIN + SETTLE; j++) begin
      if (pulse_mid && j == 5) begin
        i_cfg_valid = 1'b1;
        i_cfg_ratio = 4'd2;
      end else begin
        i_cfg_valid = 1'b0;
      end
      tick();
      set_exp((j == DRAIN + SETTLE) ? en_req : 1'b0,
              (j >= DRAIN) ? new_r : old_r,
              (j == DRAIN + SETTLE),
              (j <  DRAIN + SETTLE));
    end
    i_cfg_valid = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    i_enable    = 1'b0;
    i_cfg_valid = 1'b0;
    i_cfg_ratio = 4'd0;
    set_exp(1'b0, 4'd1, 1'b1, 1'b0);
    tick();
    chk_on = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    tick();

    // Enable from OFF: clk_en rises one cycle after i_enable is sampled
    i_enable = 1'b1;
    tick();
    set_exp(1'b1, 4'd1, 1'b1, 1'b0);
    tick();

    // Reconfigure to 7 while running
    reconfig(4'd7, 4'd1, 1'b1, 1'b0);
    tick();

    // Ratio 0 rejected, equal ratio acknowledged without an enable drop
    push_ev(1'b1, 4'd7, cyc + 1);
    i_cfg_valid = 1'b1;
    i_cfg_ratio = 4'd0;
    tick();
    i_cfg_valid = 1'b0;
    tick();
    push_ev(1'b0, 4'd7, cyc + 1);
    i_cfg_valid = 1'b1;
    i_cfg_ratio = 4'd7;
    tick();
    i_cfg_valid = 1'b0;
    tick();
    tick();

    // Request 3 with enable dropped; ends in OFF, mid-drain request ignored
    reconfig(4'd3, 4'd7, 1'b0, 1'b1);
    tick();

    // OFF: immediate ratio update
    push_ev(1'b0, 4'd5, cyc + 1);
    i_cfg_valid = 1'b1;
    i_cfg_ratio = 4'd5;
    tick();
    i_cfg_valid = 1'b0;
    set_exp(1'b0, 4'd5, 1'b1, 1'b0);
    tick();

    // OFF with enable and a new ratio: update and go to RUN together
    push_ev(1'b0, 4'd7, cyc + 1);
    i_cfg_valid = 1'b1;
    i_cfg_ratio = 4'd7;
    i_enable    = 1'b1;
    tick();
    i_cfg_valid = 1'b0;
    set_exp(1'b1, 4'd7, 1'b1, 1'b0);
    tick();

    // Reset mid-drain toward 9: no done for 9 may ever appear
    i_cfg_valid = 1'b1;
    i_cfg_ratio = 4'd9;
    tick();
    i_cfg_valid = 1'b0;
    set_exp(1'b0, 4'd7, 1'b0, 1'b1);
    for (int j = 1; j <= 8; j++) begin
      tick();
    end
    rst_n    = 1'b0;
    i_enable = 1'b0;
    set_exp(1'b0, 4'd1, 1'b1, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int j = 0; j < 24; j++) begin
      tick();
    end
    stim_done = 1'b1;
  end

  // Monitor: level checks every cycle plus scoreboard of done/err pulses
  always @(negedge clk) begin
    if (chk_on) begin
      checks++;
      if (o_clk_en !== exp_clk_en) begin
        failures++;
        $display("FAIL clk_en cyc=%0d got=%b exp=%b", cyc, o_clk_en, exp_clk_en);
      end
      checks++;
      if (o_div_ratio !== exp_ratio) begin
        failures++;
        $display("FAIL div_ratio cyc=%0d got=%0d exp=%0d", cyc, o_div_ratio, exp_ratio);
      end
      checks++;
      if (o_cfg_ready !== exp_ready || o_busy !== exp_busy) begin
        failures++;
        $display("FAIL ready_busy cyc=%0d got=%b%b exp=%b%b", cyc, o_cfg_ready, o_busy,
                 exp_ready, exp_busy);
      end
      if (o_cfg_done === 1'b1 || o_cfg_err === 1'b1) begin
        checks++;
        if (o_cfg_done === 1'b1 && o_cfg_err === 1'b1) begin
          failures++;
          $display("FAIL done_err_both cyc=%0d got=11 exp=one-hot", cyc);
        end else if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event cyc=%0d done=%b err=%b ratio=%0d exp=none",
                   cyc, o_cfg_done, o_cfg_err, o_div_ratio);
        end else begin
          ev_t e;
          e = sb.pop_front();
          if (o_cfg_err !== e.is_err || o_div_ratio !== e.ratio || cyc != e.cyc) begin
            failures++;
            $display("FAIL event cyc=%0d err=%b ratio=%0d exp cyc=%0d err=%b ratio=%0d",
                     cyc, o_cfg_err, o_div_ratio, e.cyc, e.is_err, e.ratio);
          end
        end
      end
    end
    if (stim_done) begin
      checks++;
      if (sb.size() != 0) begin
        failures++;
        $display("FAIL missing_events got=%0d exp=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end else if (cyc > 2000) begin
      checks++;
      failures++;
      $display("FAIL timeout cyc=%0d exp<=2000", cyc);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

endmodule

// File: doc/clk_div_cfg.md
Name: clk_div_cfg

Overview:
Configuration front-end that sits directly upstream of the clock divider and drives its enable and ratio inputs. It accepts ratio-change requests from the register file / system controller, stops the divider, waits for it to drain, loads the new ratio and re-enables it. This guarantees the divider never sees its ratio change while it is running. It also rejects illegal ratios and gates the divider from a global enable.

Parameters:
RATIO_WD, 4, width of the ratio bus; must equal the divider's RATIO_WD.
RESET_RATIO, 1, value of o_div_ratio after reset; must be non-zero.
DRAIN_CYC, 16, ref-clock cycles the divider enable is held low before the ratio is changed; must be >= 2 and >= 2^RATIO_WD.
SETTLE_CYC, 2, ref-clock cycles between the ratio update and enable reassertion; must be >= 1.

Ports:
i_ref_clk  in  1  reference clock; same clock as the divider.
i_rst  in  1  reset, asynchronous, active-low.
i_enable  in  1  global divider enable from the system controller.
i_cfg_ratio  in  RATIO_WD  requested division ratio.
i_cfg_valid  in  1  request strobe; sampled only while o_cfg_ready=1.
o_cfg_ready  out  1  block can accept a request.
o_cfg_done  out  1  1-cycle pulse: the new ratio has been driven on o_div_ratio.
o_cfg_err  out  1  1-cycle pulse: the request was rejected (ratio 0).
o_busy  out  1  reconfiguration in progress.
o_clk_en  out  1  to divider i_clk_en.
o_div_ratio  out  RATIO_WD  to divider i_div_ratio.

Behaviour:
- All outputs are registered except o_cfg_ready and o_busy, which decode the state register.
- Reset (i_rst=0, asynchronous): state=OFF, o_clk_en=0, o_div_ratio=RESET_RATIO, o_cfg_done=0, o_cfg_err=0, drain/settle counter=0.
- States:
  - OFF: o_clk_en=0, o_cfg_ready=1.
  - RUN: o_clk_en=1, o_cfg_ready=1.
  - DRAIN: o_clk_en=0, o_busy=1, o_cfg_ready=0.
  - SETTLE: o_clk_en=0, o_busy=1, o_cfg_ready=0.
- A request is accepted when o_cfg_ready=1 and i_cfg_valid=1 at a rising edge.
  - i_cfg_ratio=0: rejected. o_cfg_err=1 for the next cycle; state and ratio are unchanged.
  - i_cfg_ratio equal to the current o_div_ratio: accepted. o_cfg_done pulses next cycle; no state change and no enable glitch.
- OFF + accepted new ratio: o_div_ratio takes the new value at the same edge and o_cfg_done pulses. State stays OFF, or goes to RUN if i_enable=1.
- OFF + i_enable=1 (no request): RUN at the next edge, so o_clk_en rises 1 cycle after i_enable is sampled high.
- RUN + accepted new ratio at edge k:
  - Edge k: new ratio latched into a pending register; state=DRAIN; o_clk_en=0; counter cleared.
  - Edge k+DRAIN_CYC: o_div_ratio=pending; o_cfg_done=1 for 1 cycle; state=SETTLE.
  - Edge k+DRAIN_CYC+SETTLE_CYC: state=RUN (o_clk_en=1) if i_enable=1, else OFF.
  - With defaults: ratio updates at k+16, enable returns at k+18.
- RUN + i_enable=0 with no request: OFF at the next edge.
- RUN + i_enable=0 and a valid request in the same cycle: the request wins and DRAIN starts. The sequence completes and ends in OFF.
- i_enable toggling during DRAIN/SETTLE: ignored until the end of SETTLE. Only its value at the final edge selects RUN or OFF.
- i_cfg_valid during DRAIN/SETTLE: ignored; no err and no done.
- Counter width is $clog2(max(DRAIN_CYC,SETTLE_CYC)+1). The counter saturates and never wraps.
- Reset asserted mid-sequence: immediate return to reset values; the pending ratio is discarded.
- o_cfg_done and o_cfg_err are never high in the same cycle.

Test Plan:
1. Reset release with i_enable=0 -> o_div_ratio=1, o_clk_en=0, o_cfg_ready=1. Raise i_enable -> o_clk_en=1 one cycle later.
2. In RUN, request ratio 7 at edge k -> o_clk_en=0 from k. o_div_ratio=7 and o_cfg_done pulse at k+16. o_clk_en=1 at k+18. o_busy high from k to k+17.
3. In OFF, request ratio 5 -> o_div_ratio=5 and o_cfg_done at the next edge; o_clk_en stays 0.
4. Request ratio 0 in RUN -> o_cfg_err 1-cycle pulse, ratio unchanged, o_clk_en stays 1. Request ratio equal to the current value -> o_cfg_done pulse, o_clk_en never drops.
5. In RUN, request ratio 3 together with i_enable=0 -> full drain/settle. At k+16 o_div_ratio=3; ends in OFF with o_clk_en=0. A request pulsed during DRAIN has no effect.
6. Assert i_rst at k+8 of a reconfiguration to 9 from ratio 7 -> o_div_ratio=1 and o_clk_en=0 immediately (asynchronous). No o_cfg_done ever appears for 9.
